sram_banked_1w1r_param: RTL and testbench
=========================================

SRAM_BANKED_1W1R_PARAM -- requirements
Module: sram_banked_1w1r_param

Interface
REQ-001 SHALL provide parameter ABITS, default 15, word-address width (total depth 2^ABITS words).
REQ-002 SHALL provide parameter DBITS, default 8, data word width in bits.
REQ-003 SHALL provide parameter BANK_ABITS, default 14, per-bank address width; NBANKS = 2^(ABITS-BANK_ABITS); elaboration SHALL fail if BANK_ABITS > ABITS.
REQ-004 SHALL provide parameter OUT_REG, default 0, extra read output register stage (0 or 1).
REQ-005 SHALL provide parameter CLEAR_ON_RESET, default 1, zero-fill of all words after reset (0 or 1).
REQ-006 SHALL have port CLK  input  1  single clock; all state on rising edge.
REQ-007 SHALL have port RSTN  input  1  reset, asynchronous assert, active-low.
REQ-008 SHALL have port READY  output  1  high when accepting port accesses.
REQ-009 SHALL have port CE0  input  1  write-port enable.
REQ-010 SHALL have port A0  input  ABITS  write address.
REQ-011 SHALL have port D0  input  DBITS  write data.
REQ-012 SHALL have port WE0  input  1  write enable.
REQ-013 SHALL have port WEM0  input  DBITS  per-bit write mask, 1 = write bit.
REQ-014 SHALL have port CE1  input  1  read-port enable.
REQ-015 SHALL have port A1  input  ABITS  read address.
REQ-016 SHALL have port Q1  output  DBITS  read data, registered.
REQ-017 SHALL have port Q1_VALID  output  1  one-cycle pulse marking new Q1 data.

Function
REQ-018 SHALL split storage into NBANKS vertical banks of 2^BANK_ABITS x DBITS; bank index = A[ABITS-1:BANK_ABITS], offset = A[BANK_ABITS-1:0]; only the addressed bank is enabled per access.
REQ-019 SHALL implement FSM states CLEAR and RUN; after reset release, state = CLEAR if CLEAR_ON_RESET=1, else RUN.
REQ-020 In CLEAR, SHALL write zero to offset cnt of every bank in parallel each cycle, cnt counting 0 to 2^BANK_ABITS-1, then transition to RUN on the cycle after cnt = 2^BANK_ABITS-1 is written.
REQ-021 READY SHALL be 1 only in RUN; in CLEAR, CE0/CE1 SHALL be ignored (no write, no Q1_VALID).
REQ-022 In RUN, write: CE0=1 and WE0=1 SHALL update bit i of word A0 iff WEM0[i]=1; other bits unchanged; CE0=1 with WE0=0 SHALL be a no-op.
REQ-023 In RUN, read: CE1=1 SHALL load word A1 into Q1 with latency 1+OUT_REG cycles, and Q1_VALID SHALL be 1 for exactly that cycle.
REQ-024 Bank select for the read mux SHALL be registered alongside the read so Q1 always reflects the bank addressed at issue.
REQ-025 Q1 SHALL hold its last value when no read completes.
REQ-026 Same-cycle collision (CE0&WE0&CE1, A0==A1) SHALL return write-first data: bit i = WEM0[i] ? D0[i] : old[i]; no error or halt.
REQ-027 Back-to-back reads SHALL be fully pipelined: one read accepted per cycle, results in issue order.
REQ-028 Accesses to different banks or offsets in the same cycle SHALL proceed independently.

Reset
REQ-029 RSTN=0 SHALL asynchronously set READY=0, Q1=0, Q1_VALID=0, cnt=0, pipeline valid flags=0; memory contents are not reset.
REQ-030 RSTN asserted mid-CLEAR or mid-read SHALL abort the operation; in-flight reads SHALL never raise Q1_VALID after release; CLEAR restarts from cnt=0.

Verification
REQ-031 Defaults, release reset -> READY=0 for exactly 16384 cycles, then 1; read of A1=0x7FFF -> Q1=0x00, Q1_VALID one cycle later.
REQ-032 Write A0=0x4001 D0=0xA5 WEM0=0xFF, then WEM0=0x0F D0=0x3C same address, read -> Q1=0xAC.
REQ-033 Same-cycle write A0=A1=0x0010 D0=0xFF WEM0=0xF0 over stored 0x12 -> Q1=0xF2; memory then reads 0xF2.
REQ-034 OUT_REG=1, reads issued on 4 consecutive cycles alternating banks 0/1 -> four Q1_VALID pulses starting 2 cycles after first issue, data in order.
REQ-035 RSTN pulsed low during CLEAR at cnt=100 and during an in-flight read -> Q1=0, no Q1_VALID, CLEAR rerun for full 2^BANK_ABITS cycles.
REQ-036 ABITS=12, BANK_ABITS=10, DBITS=32, CLEAR_ON_RESET=0 -> READY=1 on first cycle after reset; write/read of all 4 banks at top offset 0x3FF returns written data.

Source files
------------

// File: rtl/sram_banked_1w1r_param.sv
// ---------------------------------------------------------------------------
// sram_banked_1w1r_param
//   Banked single-clock memory with one write port and one read port.
//   Storage is split into NBANKS vertical banks of 2^BANK_ABITS words. The
//   upper address bits select the bank and the lower bits select the offset.
//   Only the addressed bank is enabled for each access. After reset an
//   optional CLEAR phase zero-fills every bank in parallel. READY stays low
//   for the whole CLEAR phase.
//
// Handshake: an access is accepted on a rising CLK edge only while READY=1.
//   While READY=0, CE0 and CE1 are ignored. The read data appears on Q1 and
//   is qualified by a one-cycle Q1_VALID pulse 1+OUT_REG cycles after issue.
//   Results come out in issue order, one per cycle. Q1 holds its value
//   between pulses.
//
// Ports
//   CLK       in   clock, rising edge
//   RSTN      in   asynchronous active-low reset
//   READY     out  high while accesses are accepted (RUN state)
//   CE0/WE0   in   write enable pair; both must be high to write
//   A0/D0     in   write address / data
//   WEM0      in   per-bit write mask, 1 = write that bit
//   CE1/A1    in   read enable / address
//   Q1        out  read data
//   Q1_VALID  out  one-cycle pulse marking new Q1 data
//   DBG_STATE out  FSM state (0 = CLEAR, 1 = RUN)
// ---------------------------------------------------------------------------
module sram_banked_1w1r_param #(
  parameter int ABITS          = 15,
  parameter int DBITS          = 8,
  parameter int BANK_ABITS     = 14,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic             CLK,
  input  logic             RSTN,
  output logic             READY,
  input  logic             CE0,
  input  logic [ABITS-1:0] A0,
  input  logic [DBITS-1:0] D0,
  input  logic             WE0,
  input  logic [DBITS-1:0] WEM0,
  input  logic             CE1,
  input  logic [ABITS-1:0] A1,
  output logic [DBITS-1:0] Q1,
  output logic             Q1_VALID,
  output logic             DBG_STATE
);

  localparam int NB_BITS = (ABITS >= BANK_ABITS) ? (ABITS - BANK_ABITS) : 0;
  localparam int NBANKS  = 1 << NB_BITS;
  localparam int BIDX_W  = (NB_BITS > 0) ? NB_BITS : 1;
  localparam int DEPTH   = 1 << BANK_ABITS;

  if (BANK_ABITS > ABITS) begin : g_bad_params
    $error("BANK_ABITS must not exceed ABITS");
  end

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam state_t ST_INIT = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  state_t                state_q, state_d;
  logic [BANK_ABITS-1:0] cnt_q, cnt_d;
  logic                  clr_active;
  logic                  run_active;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------- FSM: next state ----------------
  // The last CLEAR cycle writes offset 2^BANK_ABITS-1. The counter then wraps
  // to 0 as the FSM enters RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {BANK_ABITS{1'b1}}) state_d = ST_RUN;
      end
      default: ;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // READY is also forced low by RSTN directly. This keeps it at 0 during reset
  // even when the FSM resets straight into RUN.
  always_comb begin
    clr_active = (state_q == ST_CLEAR);
    run_active = (state_q == ST_RUN);
    READY      = run_active & RSTN;
    DBG_STATE  = state_q;
  end

  // ---------------- address decode ----------------
  logic [BIDX_W-1:0]     wbank, rbank;
  logic [BANK_ABITS-1:0] woff, roff;
  logic                  wr_en, rd_en;

  if (NB_BITS > 0) begin : g_bidx
    assign wbank = A0[ABITS-1:BANK_ABITS];
    assign rbank = A1[ABITS-1:BANK_ABITS];
  end else begin : g_bidx_single
    assign wbank = '0;
    assign rbank = '0;
  end

  assign woff  = A0[BANK_ABITS-1:0];
  assign roff  = A1[BANK_ABITS-1:0];
  assign wr_en = run_active & CE0 & WE0;
  assign rd_en = run_active & CE1;

  // ---------------- banks ----------------
  logic [NBANKS-1:0][DBITS-1:0] bank_dout;

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic [DBITS-1:0] mem [DEPTH];
    logic [DBITS-1:0] rdata_q;
    logic             bank_wr, bank_rd, collide;

    assign bank_wr = wr_en && (wbank == BIDX_W'(b));
    assign bank_rd = rd_en && (rbank == BIDX_W'(b));
    assign collide = bank_wr && (woff == roff);

    // Memory contents are deliberately not reset. A same-address read in the
    // write cycle returns the merged (write-first) word.
    always_ff @(posedge CLK) begin
      if (clr_active)
        mem[cnt_q] <= '0;
      else if (bank_wr)
        mem[woff] <= (mem[woff] & ~WEM0) | (D0 & WEM0);
      if (bank_rd)
        rdata_q <= collide ? ((mem[roff] & ~WEM0) | (D0 & WEM0)) : mem[roff];
    end

    assign bank_dout[b] = rdata_q;
  end

  // ---------------- read pipeline ----------------
  // The bank select is captured with the read, so the mux always points at the
  // bank that the read addressed.
  logic              v1_q;
  logic [BIDX_W-1:0] sel_q;
  logic [DBITS-1:0]  hold_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      v1_q   <= 1'b0;
      sel_q  <= '0;
      hold_q <= '0;
    end else begin
      v1_q <= rd_en;
      if (rd_en) sel_q <= rbank;
      if (v1_q) hold_q <= bank_dout[sel_q];
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic v2_q;
    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) v2_q <= 1'b0;
      else       v2_q <= v1_q;
    end
    assign Q1       = hold_q;
    assign Q1_VALID = v2_q;
  end else begin : g_no_out_reg
    // The bank output register is the output stage here. hold_q keeps Q1
    // stable once another read to the same bank overwrites that register.
    assign Q1       = v1_q ? bank_dout[sel_q] : hold_q;
    assign Q1_VALID = v1_q;
  end

endmodule

// File: tb/tb_sram_banked_1w1r_param.sv
module tb_sram_banked_1w1r_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- dut0 (defaults) and dut1 (OUT_REG=1) share stimulus ----------------
  logic        ce0 = 0, we0 = 0, ce1 = 0;
  logic [14:0] a0 = '0, a1 = '0;
  logic [7:0]  d0 = '0, wem0 = '0;

  logic       rdy0, v0, st0;
  logic [7:0] q0;
  logic       rdy1, v1, st1;
  logic [7:0] q1;

  sram_banked_1w1r_param dut0 (
    .CLK(clk), .RSTN(rstn), .READY(rdy0), .CE0(ce0), .A0(a0), .D0(d0), .WE0(we0),
    .WEM0(wem0), .CE1(ce1), .A1(a1), .Q1(q0), .Q1_VALID(v0), .DBG_STATE(st0)
  );

  sram_banked_1w1r_param #(.OUT_REG(1)) dut1 (
    .CLK(clk), .RSTN(rstn), .READY(rdy1), .CE0(ce0), .A0(a0), .D0(d0), .WE0(we0),
    .WEM0(wem0), .CE1(ce1), .A1(a1), .Q1(q1), .Q1_VALID(v1), .DBG_STATE(st1)
  );

  // ---------------- dut2 (4 banks x 1024 x 32, no clear) ----------------
  logic        c2_ce0 = 0, c2_we0 = 0, c2_ce1 = 0;
  logic [11:0] c2_a0 = '0, c2_a1 = '0;
  logic [31:0] c2_d0 = '0, c2_wem0 = '0;
  logic        rdy2, v2, st2;
  logic [31:0] q2;

  sram_banked_1w1r_param #(.ABITS(12), .BANK_ABITS(10), .DBITS(32), .CLEAR_ON_RESET(0)) dut2 (
    .CLK(clk), .RSTN(rstn), .READY(rdy2), .CE0(c2_ce0), .A0(c2_a0), .D0(c2_d0), .WE0(c2_we0),
    .WEM0(c2_wem0), .CE1(c2_ce1), .A1(c2_a1), .Q1(q2), .Q1_VALID(v2), .DBG_STATE(st2)
  );

  // ---------------- scoreboard ----------------
  logic [7:0]  exp_q0[$];
  logic [7:0]  exp_q1[$];
  logic [31:0] exp_q2[$];
  int          cyc_q0[$];
  int          cyc_q1[$];
  int          cyc_q2[$];
  logic [7:0]  last0 = '0, last1 = '0;

  always @(negedge clk) begin
    if (rstn && v0) begin
      checks++;
      if (exp_q0.size() == 0) begin
        errors++;
        $display("FAIL dut0_unexpected_valid: got q1=%0h at cyc %0d, expected no pulse", q0, cyc);
      end else begin
        automatic logic [7:0] e = exp_q0.pop_front();
        automatic int c = cyc_q0.pop_front();
        last0 = e;
        if (q0 !== e || cyc != c) begin
          errors++;
          $display("FAIL dut0_read: got %0h at cyc %0d, expected %0h at cyc %0d", q0, cyc, e, c);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && v1) begin
      checks++;
      if (exp_q1.size() == 0) begin
        errors++;
        $display("FAIL dut1_unexpected_valid: got q1=%0h at cyc %0d, expected no pulse", q1, cyc);
      end else begin
        automatic logic [7:0] e = exp_q1.pop_front();
        automatic int c = cyc_q1.pop_front();
        last1 = e;
        if (q1 !== e || cyc != c) begin
          errors++;
          $display("FAIL dut1_read: got %0h at cyc %0d, expected %0h at cyc %0d", q1, cyc, e, c);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && v2) begin
      checks++;
      if (exp_q2.size() == 0) begin
        errors++;
        $display("FAIL dut2_unexpected_valid: got q1=%0h at cyc %0d, expected no pulse", q2, cyc);
      end else begin
        automatic logic [31:0] e = exp_q2.pop_front();
        automatic int c = cyc_q2.pop_front();
        if (q2 !== e || cyc != c) begin
          errors++;
          $display("FAIL dut2_read: got %0h at cyc %0d, expected %0h at cyc %0d", q2, cyc, e, c);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model for dut0/dut1 ----------------
  logic [7:0] model [int];

  function automatic logic [7:0] model_rd(input logic [14:0] a);
    return model.exists(int'(a)) ? model[int'(a)] : 8'h00;
  endfunction

  // ---------------- driver tasks ----------------
  typedef struct {
    logic        ce0;
    logic        we0;
    logic [14:0] a0;
    logic [7:0]  d0;
    logic [7:0]  wem0;
    logic        ce1;
    logic [14:0] a1;
    logic [7:0]  exp_q;
  } vec_t;

  task automatic drive_vec(input vec_t v);
    @(posedge clk);
    #1;
    ce0 = v.ce0; we0 = v.we0; a0 = v.a0; d0 = v.d0; wem0 = v.wem0;
    ce1 = v.ce1; a1 = v.a1;
    if (v.ce1) begin
      exp_q0.push_back(v.exp_q); cyc_q0.push_back(cyc + 1);
      exp_q1.push_back(v.exp_q); cyc_q1.push_back(cyc + 2);
    end
    if (v.ce0 && v.we0)
      model[int'(v.a0)] = (model_rd(v.a0) & ~v.wem0) | (v.d0 & v.wem0);
  endtask

  task automatic drive2(input logic we, input logic [11:0] wa, input logic [31:0] wd,
                        input logic [31:0] wm, input logic re, input logic [11:0] ra,
                        input logic [31:0] e);
    @(posedge clk);
    #1;
    c2_ce0 = we; c2_we0 = we; c2_a0 = wa; c2_d0 = wd; c2_wem0 = wm;
    c2_ce1 = re; c2_a1 = ra;
    if (re) begin
      exp_q2.push_back(e); cyc_q2.push_back(cyc + 1);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    ce0 = 0; we0 = 0; ce1 = 0;
    c2_ce0 = 0; c2_we0 = 0; c2_ce1 = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q0.size() + exp_q1.size() + exp_q2.size()) != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_outstanding", exp_q0.size() + exp_q1.size() + exp_q2.size(), 0);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    @(negedge clk);
    while (!rdy0 && n < 20000) begin
      n++;
      @(negedge clk);
    end
    chk(name, n, 16384);
    chk({name, "_dut1"}, rdy1, 1);
  endtask

  // ---------------- stimulus ----------------
  vec_t vecs[16];

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 15'h0000, 8'h00, 8'h00, 1'b1, 15'h7FFF, 8'h00};
    vecs[1]  = '{1'b1, 1'b1, 15'h4001, 8'hA5, 8'hFF, 1'b0, 15'h0000, 8'h00};
    vecs[2]  = '{1'b1, 1'b1, 15'h4001, 8'h3C, 8'h0F, 1'b0, 15'h0000, 8'h00};
    vecs[3]  = '{1'b0, 1'b0, 15'h0000, 8'h00, 8'h00, 1'b1, 15'h4001, 8'hAC};
    vecs[4]  = '{1'b1, 1'b1, 15'h0010, 8'h12, 8'hFF, 1'b0, 15'h0000, 8'h00};
    vecs[5]  = '{1'b1, 1'b1, 15'h0010, 8'hFF, 8'hF0, 1'b1, 15'h0010, 8'hF2};
    vecs[6]  = '{1'b0, 1'b0, 15'h0000, 8'h00, 8'h00, 1'b1, 15'h0010, 8'hF2};
    vecs[7]  = '{1'b1, 1'b1, 15'h0011, 8'h55, 8'hFF, 1'b1, 15'h4010, 8'h00};
    vecs[8]  = '{1'b0, 1'b0, 15'h0000, 8'h00, 8'h00, 1'b1, 15'h0011, 8'h55};
    vecs[9]  = '{1'b0, 1'b0, 15'h0000, 8'h00, 8'h00, 1'b1, 15'h4001, 8'hAC};
    vecs[10] = '{1'b0, 1'b0, 15'h0000, 8'h00, 8'h00, 1'b1, 15'h0010, 8'hF2};
    vecs[11] = '{1'b0, 1'b0, 15'h0000, 8'h00, 8'h00, 1'b1, 15'h4011, 8'h00};
    vecs[12] = '{1'b0, 1'b0, 15'h0000, 8'h00, 8'h00, 1'b1, 15'h0011, 8'h55};
    vecs[13] = '{1'b1, 1'b1, 15'h7FFF, 8'h99, 8'h81, 1'b0, 15'h0000, 8'h00};
    vecs[14] = '{1'b0, 1'b0, 15'h0000, 8'h00, 8'h00, 1'b1, 15'h7FFF, 8'h81};
    vecs[15] = '{1'b1, 1'b0, 15'h0011, 8'hFF, 8'hFF, 1'b1, 15'h0011, 8'h55};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready0", rdy0, 0);
    chk("rst_ready2", rdy2, 0);
    chk("rst_q0", q0, 0);
    chk("rst_q1", q1, 0);
    chk("rst_valid0", v0, 0);
    chk("rst_valid1", v1, 0);
    @(posedge clk);
    #1;
    rstn = 1;

    // The READY=0 count for dut0 and the immediate READY of dut2 share this loop.
    begin
      int n = 0;
      @(negedge clk);
      chk("dut2_ready_first_cycle", rdy2, 1);
      while (!rdy0 && n < 20000) begin
        n++;
        @(negedge clk);
      end
      chk("clear_cycles", n, 16384);
    end

    // table-driven vectors
    for (int i = 0; i < 16; i++) drive_vec(vecs[i]);
    idle();
    drain();
    repeat (3) @(negedge clk);
    chk("hold_q0", q0, last0);
    chk("hold_q1", q1, last1);
    chk("model_after_collision", model_rd(15'h0010), 8'hF2);

    // random traffic over a small address set in both banks
    for (int i = 0; i < 300; i++) begin
      vec_t v;
      int ia, ib;
      ia = $urandom_range(0, 7);
      ib = $urandom_range(0, 7);
      v.ce0  = 1'($urandom_range(0, 1));
      v.we0  = 1'($urandom_range(0, 1));
      v.a0   = ((ia >= 4) ? 15'h4000 : 15'h0000) | 15'(ia % 4);
      v.d0   = 8'($urandom_range(0, 255));
      v.wem0 = 8'($urandom_range(0, 255));
      v.ce1  = 1'($urandom_range(0, 1));
      v.a1   = ($urandom_range(0, 1) == 1) ? v.a0
             : (((ib >= 4) ? 15'h4000 : 15'h0000) | 15'(ib % 4));
      v.exp_q = model_rd(v.a1);
      if (v.ce0 && v.we0 && v.a0 == v.a1)
        v.exp_q = (v.exp_q & ~v.wem0) | (v.d0 & v.wem0);
      drive_vec(v);
    end
    idle();
    drain();

    // dut2: top offset of every bank, then back-to-back reads
    drive2(1, 12'h3FF, 32'hDEADBEEF, 32'hFFFFFFFF, 0, 12'h000, 32'h0);
    drive2(1, 12'h7FF, 32'h01234567, 32'hFFFFFFFF, 0, 12'h000, 32'h0);
    drive2(1, 12'hBFF, 32'h89ABCDEF, 32'hFFFFFFFF, 0, 12'h000, 32'h0);
    drive2(1, 12'hFFF, 32'hCAFEF00D, 32'hFFFFFFFF, 1, 12'h3FF, 32'hDEADBEEF);
    drive2(1, 12'hBFF, 32'h00000000, 32'h0000FFFF, 1, 12'h7FF, 32'h01234567);
    drive2(0, 12'h000, 32'h0, 32'h0, 1, 12'hBFF, 32'h89AB0000);
    drive2(0, 12'h000, 32'h0, 32'h0, 1, 12'hFFF, 32'hCAFEF00D);
    idle();
    drain();

    // reset during an in-flight read: no pulse must follow release
    @(posedge clk);
    #1;
    ce1 = 1; a1 = 15'h4001;
    @(posedge clk);
    #2;
    ce1 = 0;
    rstn = 0;
    exp_q0.delete(); cyc_q0.delete();
    exp_q1.delete(); cyc_q1.delete();
    #1;
    chk("abort_q0", q0, 0);
    chk("abort_q1", q1, 0);
    chk("abort_valid0", v0, 0);
    chk("abort_valid1", v1, 0);
    chk("abort_ready", rdy0, 0);
    model.delete();
    @(posedge clk);
    #1;
    rstn = 1;

    // reset again around cnt=100 of the CLEAR phase
    repeat (100) @(posedge clk);
    #2;
    chk("midclear_ready", rdy0, 0);
    rstn = 0;
    #1;
    chk("midclear_rst_ready", rdy0, 0);
    chk("midclear_rst_q0", q0, 0);
    @(posedge clk);
    #1;
    rstn = 1;
    wait_ready("clear_rerun_cycles");

    // memory has been zero-filled again
    drive_vec('{1'b0, 1'b0, 15'h0000, 8'h00, 8'h00, 1'b1, 15'h4001, 8'h00});
    drive_vec('{1'b0, 1'b0, 15'h0000, 8'h00, 8'h00, 1'b1, 15'h0011, 8'h00});
    idle();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net: a hung run still ends with a report.
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: got cycle %0d, expected completion", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
